// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: D = A - B - BI computed one nibble per clock; optional V port via NIBBLE_SUB_OVERFLOW_EN
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             BUSY,
    output logic             DONE,
`ifdef NIBBLE_SUB_OVERFLOW_EN
    output logic             V,
`endif
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             Z
);
    localparam int N  = WIDTH / 4;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] a_q, b_q, res, res_nxt;
    logic [CW-1:0] cnt;
    logic [4:0] sum;
    logic carry, last, accept;
`ifdef NIBBLE_SUB_OVERFLOW_EN
    logic a_msb, b_msb;
`endif
    // nibble slice A + ~B + carry, result shifted in from the top, next-state decode
    always_comb begin
        sum     = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0, carry};
        res_nxt = (res >> 4) | (WIDTH'(sum[3:0]) << (WIDTH - 4));
        last    = cnt == CW'(N - 1);
        accept  = state != S_RUN && START;
        nxt     = accept ? S_RUN : state == S_RUN ? (last ? S_DONE : S_RUN) : S_IDLE;
    end
    // state, operand shifters, carry chain and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            D     <= '0;
            BO    <= 1'b0;
            Z     <= 1'b0;
`ifdef NIBBLE_SUB_OVERFLOW_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            V     <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                carry <= ~BI;
                cnt   <= '0;
                res   <= '0;
`ifdef NIBBLE_SUB_OVERFLOW_EN
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
`endif
            end else if (state == S_RUN) begin
                a_q   <= a_q >> 4;
                b_q   <= b_q >> 4;
                carry <= sum[4];
                cnt   <= cnt + 1'b1;
                res   <= res_nxt;
                if (last) begin
                    D  <= res_nxt;
                    BO <= ~sum[4];
                    Z  <= res_nxt == '0;
`ifdef NIBBLE_SUB_OVERFLOW_EN
                    V  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
                end
            end
        end
    end
    assign BUSY = state == S_RUN;
    assign DONE = state == S_DONE;
endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor. Computes D = A − B − BI, one 4-bit nibble per clock, LSB nibble first, with the borrow chained between nibbles.
- Each nibble is computed as A_nib + ~B_nib + carry, the same 4-bit carry-lookahead slice used by the adder, so the inverse operation reuses that datapath.
- Sits beside the 4-bit lookahead adder in the arithmetic block set and trades latency for area on wide operands.
- Start/done handshake toward the controlling sequencer.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibble cycles.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- START  input  1  request; sampled only when accepting (state IDLE or DONE)
- A  input  WIDTH  minuend, captured on accepted START
- B  input  WIDTH  subtrahend, captured on accepted START
- BI  input  1  borrow-in, captured on accepted START
- BUSY  output  1  high while in RUN
- DONE  output  1  single-cycle pulse; result valid
- D  output  WIDTH  difference, registered
- BO  output  1  borrow-out (1 when A < B + BI, unsigned)
- Z  output  1  1 when D == 0

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE; BUSY=0, DONE=0, D=0, BO=0, Z=0; internal operand registers, nibble counter and carry cleared. RST has priority over every other input, including mid-RUN; an operation in progress is aborted with no DONE pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: START=1 → capture A, B, BI; carry := ~BI; cnt := 0; go to RUN. Otherwise stay in IDLE.
  - RUN: each edge processes nibble cnt: {c, s} = A[4cnt+3:4cnt] + ~B[4cnt+3:4cnt] + carry (5-bit result). s is written into the internal result shift register and carry := c. cnt increments. At cnt == N−1, go to DONE.
  - DONE: DONE=1 for exactly this cycle. START=1 here is accepted exactly as in IDLE (back-to-back: straight to RUN). Otherwise go to IDLE.
- Outputs:
  - D, BO and Z load together on the RUN→DONE edge: D = assembled result, BO = ~final carry, Z = (D == 0).
  - D, BO and Z then hold until the next operation's RUN→DONE edge. They do not change on START.
  - BUSY=1 only in RUN.
- Latency: START sampled at edge 0 → N RUN edges → DONE high in the cycle after edge N. For WIDTH=16, DONE is high after edge 4. Throughput is one operation per N+1 cycles when back-to-back.
- START in RUN is ignored. A, B and BI may change freely after capture.
- Arithmetic: modulo 2^WIDTH. The borrow ripples across nibbles through the registered carry only. No combinational path from A/B to any output.
- BI=1 with A=B gives D = all-ones and BO=1.

Optional Feature:
- Macro: NIBBLE_SUB_OVERFLOW_EN.
- Defined: adds output port V (1 bit), loaded on the RUN→DONE edge alongside D. V = signed two's-complement overflow = (A[MSB] ≠ B[MSB]) && (D[MSB] ≠ A[MSB]). V resets to 0 and holds like D.
- Undefined: no V port and no overflow logic. All other behaviour is identical.

Test Plan (WIDTH=16):
- Reset, then START with A=0x0007, B=0x0003, BI=0 → BUSY=1 for 4 cycles, then DONE pulse 1 cycle with D=0x0004, BO=0, Z=0.
- A=0x0003, B=0x0007, BI=0 → D=0xFFFC, BO=1, Z=0. Then A=0x1234, B=0x1234, BI=0 → D=0x0000, BO=0, Z=1.
- Borrow ripple and borrow-in:
  - A=0x1000, B=0x0001, BI=0 → D=0x0FFF, BO=0.
  - A=0x0000, B=0x0000, BI=1 → D=0xFFFF, BO=1.
- Back-to-back: START held high through the DONE cycle with new operands A=0x0050, B=0x0010 → second DONE exactly 5 cycles after the first, D=0x0040. START pulses during RUN are ignored (no extra DONE).
- Reset mid-op: RST=1 at the 2nd RUN edge → no DONE, BUSY=0, D=0, BO=0, Z=0 on the next cycle. A following START completes normally.
- With NIBBLE_SUB_OVERFLOW_EN: A=0x8000, B=0x0001 → D=0x7FFF, V=1, BO=0. A=0x0005, B=0x0003 → V=0.
